// File: rtl/reg_alu_seq.sv
// reg_alu_seq: instruction sequencer feeding the register-file/ALU stage.
// Buffers 16-bit instruction words (valid/ready), decodes them and replays
// them as registered Moore strobes. Tracks the stage carry and supports HALT/go.
// Optional feature: define REG_ALU_SEQ_FIFO_EN for a FIFO_DEPTH-word circular
// FIFO buffer; otherwise a single-word holding register is used.
module reg_alu_seq #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    input  logic        go,
    input  logic        alu_cout,
    output logic        sel,
    output logic        wr,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_in,
    output logic        carry,
    output logic        halted,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_NOP, S_LDI_WR, S_ALU_RD, S_ALU_WR, S_HALT
    } state_t;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("reg_alu_seq: FIFO_DEPTH must be a power of two and >= 2");
    end

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic        push, pop, buf_empty, buf_full_d, buf_nonempty_d;
    logic [15:0] head;
    logic        in_ready_q;

    logic        wr_q, wr_d, sel_q, sel_d, carry_q, halted_q, halted_d, busy_q, busy_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
    logic [15:0] din_q, din_d;

    // in_ready is registered from next occupancy, so it never reacts to a same-cycle pop
    assign push = in_valid & in_ready_q;

`ifdef REG_ALU_SEQ_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;

    // Occupancy after this edge's push/pop
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    // FIFO storage, data only
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_instr;
    end

    assign buf_empty      = (count_q == '0);
    assign head           = mem_q[rptr_q];
    assign buf_full_d     = (count_d == CNT_FULL);
    assign buf_nonempty_d = (count_d != '0);
`else
    logic [15:0] hold_q;
    logic        full_q;

    // A push only happens when empty and a pop only when full, so they never coincide
    always_comb begin
        buf_full_d = full_q;
        if (push) begin
            buf_full_d = 1'b1;
        end else if (pop) begin
            buf_full_d = 1'b0;
        end
    end

    // Holding-register occupancy flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) full_q <= 1'b0;
        else        full_q <= buf_full_d;
    end

    // Holding-register data
    always_ff @(posedge clk) begin
        if (push) hold_q <= in_instr;
    end

    assign buf_empty      = ~full_q;
    assign head           = hold_q;
    assign buf_nonempty_d = buf_full_d;
`endif

    // Next state: issue-point states pop the head word when one is buffered
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pop     = 1'b0;
        case (state_q)
            S_ALU_RD: state_d = S_ALU_WR;
            S_HALT:   if (go) state_d = S_IDLE;
            default: begin
                if (!buf_empty) begin
                    pop     = 1'b1;
                    instr_d = head;
                    case (head[15:14])
                        2'b00:   state_d = S_NOP;
                        2'b01:   state_d = S_LDI_WR;
                        2'b10:   state_d = S_ALU_RD;
                        default: state_d = S_HALT;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Output values for the state being entered; addresses and op hold otherwise
    always_comb begin
        wr_d  = 1'b0;
        sel_d = 1'b0;
        din_d = '0;
        op_d  = op_q;
        ra_d  = ra_q;
        rb_d  = rb_q;
        wa_d  = wa_q;
        case (state_d)
            S_LDI_WR: begin
                wr_d  = 1'b1;
                wa_d  = instr_d[13:11];
                din_d = {8'h00, instr_d[7:0]};
            end
            S_ALU_RD, S_ALU_WR: begin
                wr_d  = (state_d == S_ALU_WR);
                sel_d = 1'b1;
                op_d  = instr_d[13:12];
                wa_d  = instr_d[11:9];
                ra_d  = instr_d[8:6];
                rb_d  = instr_d[5:3];
            end
            default: ;
        endcase
        halted_d = (state_d == S_HALT);
        busy_d   = (state_d != S_IDLE) || buf_nonempty_d;
    end

    // State and registered outputs; async reset drops every strobe immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            wr_q       <= 1'b0;
            sel_q      <= 1'b0;
            op_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            wa_q       <= '0;
            din_q      <= '0;
            carry_q    <= 1'b0;
            halted_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= ~buf_full_d;
            wr_q       <= wr_d;
            sel_q      <= sel_d;
            op_q       <= op_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            wa_q       <= wa_d;
            din_q      <= din_d;
            halted_q   <= halted_d;
            busy_q     <= busy_d;
            if (state_q == S_ALU_WR) carry_q <= alu_cout;
        end
    end

    // Decoded word being executed, data only
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
    end

    assign in_ready  = in_ready_q;
    assign wr        = wr_q;
    assign sel       = sel_q;
    assign op        = op_q;
    assign rd_addr_a = ra_q;
    assign rd_addr_b = rb_q;
    assign wr_addr   = wa_q;
    assign d_in      = din_q;
    assign carry     = carry_q;
    assign halted    = halted_q;
    assign busy      = busy_q;

endmodule

// File: doc/reg_alu_seq.md
# reg_alu_seq

Instruction sequencer that sits directly upstream of the register-file/ALU stage. It accepts 16-bit instruction words over a valid/ready handshake and buffers them. Each word is decoded and replayed as registered control strobes on the stage's `sel`, `wr`, `op`, `rd_addr_a`, `rd_addr_b`, `wr_addr` and `d_in` inputs. It also captures the stage's `cout` into a carry flag and supports a HALT/resume handshake.

## Interface
- `FIFO_DEPTH`, 4, input buffer depth in words; must be a power of two and ≥2; used only when `REG_ALU_SEQ_FIFO_EN` is defined.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction word offered.
- `in_instr`  in  16  instruction word.
- `in_ready`  out  1  buffer can accept a word this cycle.
- `go`  in  1  single-cycle resume pulse; effective only in HALT.
- `alu_cout`  in  1  carry from the downstream stage.
- `sel`  out  1  0 = write `d_in`, 1 = write the ALU result.
- `wr`  out  1  register-file write strobe.
- `op`  out  2  ALU opcode.
- `rd_addr_a`, `rd_addr_b`  out  3  read addresses.
- `wr_addr`  out  3  write address.
- `d_in`  out  16  immediate data.
- `carry`  out  1  carry flag captured on the last ALU write.
- `halted`  out  1  high while in HALT.
- `busy`  out  1  high when the FSM is not IDLE or the buffer is non-empty.

## Operation
- Instruction encoding by `in_instr[15:14]`:
  - 00 NOP.
  - 01 LDI: rd=[13:11], imm8=[7:0].
  - 10 ALU: op=[13:12], rd=[11:9], ra=[8:6], rb=[5:3].
  - 11 HALT.
  - Unused bits are ignored.
- Push: occurs when `in_valid & in_ready`. `in_ready` = not full, and depends on occupancy only, not on a same-cycle pop. A word offered while full is not taken; the source must hold it.
- FSM states: IDLE, NOP, LDI_WR, ALU_RD, ALU_WR, HALT. All outputs are registered (Moore).
- Issue point: IDLE, NOP, LDI_WR and ALU_WR are issue points.
  - With the buffer non-empty, the FSM pops the head word and goes to its first state: NOP, LDI_WR, ALU_RD or HALT.
  - With the buffer empty, the FSM goes to IDLE.
- ALU_RD always transitions to ALU_WR. HALT stays in HALT until `go`=1, then transitions to IDLE.
- Output values per state:
  - IDLE, NOP, HALT: `wr`=0, `sel`=0, `d_in`=0. Addresses and `op` hold their last values.
  - LDI_WR: `wr`=1, `sel`=0, `wr_addr`=rd, `d_in`={8'h00, imm8}.
  - ALU_RD: `wr`=0, `sel`=1, `op`=op, `rd_addr_a`=ra, `rd_addr_b`=rb, `wr_addr`=rd, `d_in`=0.
  - ALU_WR: same as ALU_RD but `wr`=1.
- Carry: `carry` is loaded from `alu_cout` at the clock edge ending an ALU_WR cycle. It is unchanged otherwise.
- Hazards: every write completes before the next instruction's read cycle, so no forwarding is needed. An ALU instruction with rd==ra reads the old value.
- HALT: the buffer keeps accepting words while halted. `go` outside HALT is ignored.
- Reset (`reset`=0, asynchronous):
  - Buffer is emptied and the FSM goes to IDLE.
  - All outputs go to 0: `in_ready`=0 during reset, `carry`=0, `halted`=0, `busy`=0.
  - An instruction in flight is abandoned; `wr` drops immediately, not at the next edge.
- After reset is released, `in_ready`=1 at the first edge.

## Timing
- Latency: a word pushed at edge E into an empty buffer with the FSM in IDLE is popped at E+1. Its first state's outputs are valid from E+1 until E+2.
- Throughput:
  - LDI and NOP: 1 cycle each.
  - ALU: 2 cycles.
  - HALT: ≥1 cycle, plus the wait for `go`.
- Back-to-back issue without an IDLE cycle whenever the buffer is non-empty at an issue point.
- `go` sampled at edge G in HALT: IDLE is entered at G. The next word is popped at G+1.
- Simultaneous push and pop on a non-full buffer: both take effect and occupancy is unchanged.

## Configuration
- `REG_ALU_SEQ_FIFO_EN` defined: the buffer is a circular FIFO of `FIFO_DEPTH` words with wrap-around read and write pointers.
- `REG_ALU_SEQ_FIFO_EN` not defined: the buffer is a single-word holding register, so `in_ready` = register empty. All FSM and timing rules are otherwise identical.

## Test plan
- Reset, then push LDI r3,#0xA5 (word 16'h58A5) → one cycle with `wr`=1, `sel`=0, `wr_addr`=3, `d_in`=16'h00A5, two cycles after the push.
- Push ALU op=01 rd=7, ra=1, rb=2 (word 16'h9E50) with `alu_cout`=1 → ALU_RD with `wr`=0, then ALU_WR with `wr`=1, `sel`=1, `op`=01. `carry`=1 afterwards.
- Push 4 words with FIFO enabled while the FSM is halted → `in_ready` drops after the 4th. A 5th `in_valid` is not accepted until a pop occurs.
- Push HALT then LDI → `halted`=1 and no `wr` for 10 cycles. Pulse `go` → `halted`=0 and the LDI write follows within 2 cycles.
- Assert `reset`=0 during ALU_WR → `wr`, `sel` and `d_in` go to 0 asynchronously. After release, `busy`=0 and the buffer is empty.
- With the FIFO compiled out, stream three LDIs with `in_valid` held high → exactly one LDI in flight at a time. All three writes occur in order with correct `wr_addr` and `d_in`.
